ib_mac_acc: RTL and testbench
=============================

# ib_mac_acc

Streaming accumulator that sits directly downstream of the 8x8 combinational multipliers and consumes their 16-bit products. It sums a burst of products, delimited by a last flag, into a wide accumulator and presents the total, term count and overflow flag on a valid/ready output. This turns a bare multiplier into a benchmarkable multiply-accumulate datapath.

## Interface

Parameters:
- ACC_W, 20: accumulator width in bits; legal range ACC_W >= 16.
- CNT_W, 8: term-counter width in bits; legal range CNT_W >= 1.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_prod_vld  in  1  product valid.
- o_prod_rdy  out  1  product ready.
- i_prod  in  16  unsigned product from the multiplier.
- i_prod_last  in  1  marks the final product of a burst; qualified by a product transfer.
- o_acc_vld  out  1  result valid.
- i_acc_rdy  in  1  result ready.
- o_acc  out  ACC_W  accumulated sum.
- o_acc_cnt  out  CNT_W  number of products accepted in the burst.
- o_ovf  out  1  sticky flag: the sum exceeded 2^ACC_W-1 during the burst.

## Operation

- States: ACC and DONE. Reset enters ACC.
- Transfer rules: a product transfer occurs when i_prod_vld and o_prod_rdy are both high. A result transfer occurs when o_acc_vld and i_acc_rdy are both high.
- ACC state:
  - o_prod_rdy = 1 and o_acc_vld = 0.
  - On a product transfer: acc <= acc + zero-extended i_prod, computed at ACC_W+1 bits.
  - On the same transfer, cnt <= cnt+1, saturating at 2^CNT_W-1.
  - If bit ACC_W of the sum is set, o_ovf <= 1.
  - If i_prod_last is set on the transfer, move to DONE.
- DONE state:
  - o_prod_rdy = 0 and o_acc_vld = 1.
  - o_acc, o_acc_cnt and o_ovf hold stable until the result transfer.
  - On the result transfer: acc, cnt and o_ovf clear to 0 and the state returns to ACC.
- Input while not ready: i_prod_vld while in DONE is ignored. Upstream must hold its data, which is standard valid/ready behaviour.
- Single-term burst: a burst of one product (last on the first transfer) gives o_acc = i_prod and o_acc_cnt = 1.
- Counter saturation: the counter stops at all-ones. It has no effect on o_acc.
- Empty burst: not possible. A result always contains at least one term.
- o_acc_vld does not depend combinationally on i_acc_rdy. o_prod_rdy does not depend combinationally on i_prod_vld.

## Timing

- Reset values: state = ACC, o_acc = 0, o_acc_cnt = 0, o_ovf = 0, o_acc_vld = 0, o_prod_rdy = 1 (asserted as soon as i_nrst is low).
- Throughput: one product per cycle during a burst.
- Latency: o_acc_vld rises in the cycle after the transfer carrying i_prod_last.
- Bubble: one idle input cycle per result minimum. A result transfer in cycle N puts ACC in cycle N+1, so a new product can be accepted in N+1.
- Back-pressure: the result is held indefinitely while i_acc_rdy = 0.
- Reset mid-operation: asserting i_nrst in either state aborts the burst immediately. Partial sum, count and flag are discarded and all outputs return to their reset values.
- Outputs o_acc, o_acc_cnt, o_ovf and o_acc_vld are registered. o_prod_rdy is decoded from the state register only.

## Configuration

- IB_MAC_ACC_SAT_EN defined: on overflow, acc loads 2^ACC_W-1 (all ones) and stays there for the rest of the burst. o_ovf is set.
- IB_MAC_ACC_SAT_EN undefined: acc wraps modulo 2^ACC_W. o_ovf is still set on the carry out.
- All other behaviour is identical in both builds.

## Test plan

- Reset with i_nrst low and i_prod_vld = 1:
  - Required: o_prod_rdy = 1, o_acc_vld = 0, all data outputs 0.
  - After release, no accumulation occurs until the first clock edge with vld high.
- Burst 3×4, 7×9, 255×255 (products 12, 63, 65025), last on the third, i_acc_rdy = 1:
  - o_acc_vld is high in the cycle after the last transfer.
  - Required: o_acc = 65100, o_acc_cnt = 3, o_ovf = 0.
  - The first product of the next burst is accepted one cycle later.
- ACC_W = 20, 16 products of 65025:
  - Required: o_acc = 1040400, o_ovf = 0.
- ACC_W = 20, 17 products of 65025:
  - With the macro: o_acc = 1048575, o_ovf = 1.
  - Without the macro: o_acc = 56849, o_ovf = 1.
  - The next burst starts with o_ovf = 0.
- Back-pressure: i_acc_rdy held 0 for 10 cycles after a result while i_prod_vld = 1 with product 5.
  - Required: o_prod_rdy = 0 throughout, and the outputs stay stable.
  - On release, a single result transfer occurs and the held product 5 is accepted as the first term of the next burst.
- Mid-burst abort:
  - Stimulus: i_nrst pulsed low after 2 products of 100, then a 1-product burst of 7.
  - Required: the result is o_acc = 7, o_acc_cnt = 1.

Source files
------------

// File: rtl/ib_mac_acc.sv
// Streaming multiply-accumulate back end: sums a last-delimited burst of 16-bit products
// and returns the sum, term count and overflow flag over valid/ready. IB_MAC_ACC_SAT_EN selects saturation over wrap.
module ib_mac_acc #(
    parameter int unsigned ACC_W = 20,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_prod_vld,
    output logic             o_prod_rdy,
    input  logic [15:0]      i_prod,
    input  logic             i_prod_last,
    output logic             o_acc_vld,
    input  logic             i_acc_rdy,
    output logic [ACC_W-1:0] o_acc,
    output logic [CNT_W-1:0] o_acc_cnt,
    output logic             o_ovf
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SUM_W-1:0]   sum_c;
    logic [ACC_W-1:0]   acc_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               ovf_nxt;
    logic               prod_xfer;
    logic               acc_xfer;

    // Ready is a pure state decode so it never depends on i_prod_vld.
    assign o_prod_rdy = (state == ST_ACC);
    assign prod_xfer  = i_prod_vld && o_prod_rdy;
    assign acc_xfer   = o_acc_vld && i_acc_rdy;
    assign sum_c      = {1'b0, o_acc} + SUM_W'(i_prod);

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state     <= ST_ACC;
            o_acc     <= '0;
            o_acc_cnt <= '0;
            o_ovf     <= 1'b0;
            o_acc_vld <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_acc     <= acc_nxt;
            o_acc_cnt <= cnt_nxt;
            o_ovf     <= ovf_nxt;
            o_acc_vld <= (state_nxt == ST_DONE);
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:  if (prod_xfer && i_prod_last) state_nxt = ST_DONE;
            ST_DONE: if (acc_xfer)                 state_nxt = ST_ACC;
            default: state_nxt = ST_ACC;
        endcase
    end

    // Datapath next values: accumulate in ACC, hold in DONE, clear on result handoff.
    always_comb begin
        acc_nxt = o_acc;
        cnt_nxt = o_acc_cnt;
        ovf_nxt = o_ovf;
        case (state)
            ST_ACC: begin
                if (prod_xfer) begin
`ifdef IB_MAC_ACC_SAT_EN
                    acc_nxt = sum_c[SUM_W-1] ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];
`else
                    acc_nxt = sum_c[ACC_W-1:0];
`endif
                    cnt_nxt = (&o_acc_cnt) ? o_acc_cnt : o_acc_cnt + CNT_W'(1);
                    if (sum_c[SUM_W-1]) ovf_nxt = 1'b1;
                end
            end
            ST_DONE: begin
                if (acc_xfer) begin
                    acc_nxt = '0;
                    cnt_nxt = '0;
                    ovf_nxt = 1'b0;
                end
            end
            default: begin
                acc_nxt = '0;
                cnt_nxt = '0;
                ovf_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ib_mac_acc.sv
// Scoreboard bench for ib_mac_acc: directed bursts plus randomized bursts checked against
// an arithmetic model of the burst total (build with or without IB_MAC_ACC_SAT_EN).
module tb_ib_mac_acc;

    localparam int unsigned ACC_W = 20;
    localparam int unsigned CNT_W = 8;

    typedef struct {
        longint acc;
        longint cnt;
        longint ovf;
    } exp_t;

    logic             i_clk;
    logic             i_nrst;
    logic             i_prod_vld;
    logic             o_prod_rdy;
    logic [15:0]      i_prod;
    logic             i_prod_last;
    logic             o_acc_vld;
    logic             i_acc_rdy;
    logic [ACC_W-1:0] o_acc;
    logic [CNT_W-1:0] o_acc_cnt;
    logic             o_ovf;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    bit   rdy_rand  = 1'b0;
    bit   rdy_force = 1'b1;

    ib_mac_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_prod_vld  (i_prod_vld),
        .o_prod_rdy  (o_prod_rdy),
        .i_prod      (i_prod),
        .i_prod_last (i_prod_last),
        .o_acc_vld   (o_acc_vld),
        .i_acc_rdy   (i_acc_rdy),
        .o_acc       (o_acc),
        .o_acc_cnt   (o_acc_cnt),
        .o_ovf       (o_ovf)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic void chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Burst total from the true (unbounded) sum: products are non-negative, so overflow
    // happened iff the true sum exceeds the accumulator range.
    function automatic exp_t model(input longint sum, input int n);
        exp_t   e;
        longint amax = (longint'(1) <<< ACC_W) - 1;
        longint cmax = (longint'(1) <<< CNT_W) - 1;
`ifdef IB_MAC_ACC_SAT_EN
        e.acc = (sum > amax) ? amax : sum;
`else
        e.acc = sum % (amax + 1);
`endif
        e.ovf = (sum > amax) ? 1 : 0;
        e.cnt = (longint'(n) > cmax) ? cmax : longint'(n);
        return e;
    endfunction

    // Result-ready driver.
    initial begin
        i_acc_rdy = 1'b1;
        forever begin
            @(posedge i_clk);
            #1 i_acc_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Monitor: every result handoff is popped from the scoreboard and compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_nrst && o_acc_vld && i_acc_rdy) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_acc", longint'(o_acc), e.acc);
                    chk("res_cnt", longint'(o_acc_cnt), e.cnt);
                    chk("res_ovf", longint'(o_ovf), e.ovf);
                end
            end
        end
    end

    // Present one product and wait for it to be accepted; returns just after the transfer edge.
    task automatic send(input logic [15:0] p, input bit last);
        bit ok = 1'b0;
        i_prod      = p;
        i_prod_last = last;
        i_prod_vld  = 1'b1;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge i_clk);
            if (o_prod_rdy) ok = 1'b1;
            @(posedge i_clk);
            #1;
        end
        i_prod_vld = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // fixed < 0 selects random products biased toward large values.
    task automatic burst(input int n, input int fixed, input int max_gap);
        longint      sum = 0;
        logic [15:0] p;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && max_gap > 0) idle(int'($urandom_range(0, max_gap)));
            if (fixed >= 0) p = 16'(fixed);
            else begin
                case ($urandom_range(0, 3))
                    0:       p = 16'hFFFF;
                    1:       p = 16'd65025;
                    default: p = 16'($urandom_range(0, 65535));
                endcase
            end
            send(p, i == n - 1);
            sum += longint'(p);
        end
        sb_q.push_back(model(sum, n));
    endtask

    initial begin
        exp_t           e;
        logic [ACC_W-1:0] snap_acc;
        logic [CNT_W-1:0] snap_cnt;
        logic             snap_ovf;
        int               wait_cyc;

        i_nrst      = 1'b0;
        i_prod_vld  = 1'b1;
        i_prod      = 16'h1234;
        i_prod_last = 1'b1;

        // Reset held with a valid product present.
        repeat (3) @(negedge i_clk);
        chk("rst_prod_rdy", longint'(o_prod_rdy), 1);
        chk("rst_acc_vld", longint'(o_acc_vld), 0);
        chk("rst_acc", longint'(o_acc), 0);
        chk("rst_cnt", longint'(o_acc_cnt), 0);
        chk("rst_ovf", longint'(o_ovf), 0);
        @(posedge i_clk);
        #1 i_prod_vld = 1'b0;
        @(negedge i_clk);
        i_nrst = 1'b1;
        idle(3);
        @(negedge i_clk);
        chk("post_rst_idle_acc", longint'(o_acc), 0);
        chk("post_rst_idle_vld", longint'(o_acc_vld), 0);
        idle(1);

        // Directed three-term burst with the sink always ready.
        send(16'd12, 1'b0);
        send(16'd63, 1'b0);
        send(16'd65025, 1'b1);
        e.acc = 65100; e.cnt = 3; e.ovf = 0;
        sb_q.push_back(e);
        @(negedge i_clk);
        chk("lat_acc_vld", longint'(o_acc_vld), 1);
        chk("lat_prod_rdy", longint'(o_prod_rdy), 0);
        idle(1);
        chk("bubble_prod_rdy", longint'(o_prod_rdy), 1);

        // 16 and 17 terms of 65025: below and across the 20-bit boundary.
        burst(16, 65025, 0);
        idle(1);
        burst(17, 65025, 0);
        idle(1);
        chk("ovf_cleared", longint'(o_ovf), 0);
        chk("acc_cleared", longint'(o_acc), 0);
        chk("cnt_cleared", longint'(o_acc_cnt), 0);

        // Term counter saturation.
        burst(260, 1, 0);
        idle(2);

        // Back-pressure: result held while a product waits upstream.
        rdy_force = 1'b0;
        idle(1);
        burst(3, -1, 0);
        i_prod = 16'd5; i_prod_last = 1'b1; i_prod_vld = 1'b1;
        @(negedge i_clk);
        snap_acc = o_acc; snap_cnt = o_acc_cnt; snap_ovf = o_ovf;
        for (int c = 0; c < 10; c++) begin
            chk("bp_prod_rdy", longint'(o_prod_rdy), 0);
            chk("bp_acc_vld", longint'(o_acc_vld), 1);
            chk("bp_acc_hold", longint'(o_acc), longint'(snap_acc));
            chk("bp_cnt_hold", longint'(o_acc_cnt), longint'(snap_cnt));
            chk("bp_ovf_hold", longint'(o_ovf), longint'(snap_ovf));
            @(negedge i_clk);
        end
        rdy_force = 1'b1;
        send(16'd5, 1'b1);
        e.acc = 5; e.cnt = 1; e.ovf = 0;
        sb_q.push_back(e);
        idle(2);

        // Mid-burst abort by reset.
        send(16'd100, 1'b0);
        send(16'd100, 1'b0);
        chk("abort_partial_acc", longint'(o_acc), 200);
        chk("abort_partial_cnt", longint'(o_acc_cnt), 2);
        @(negedge i_clk);
        i_nrst = 1'b0;
        #1;
        chk("abort_acc", longint'(o_acc), 0);
        chk("abort_cnt", longint'(o_acc_cnt), 0);
        chk("abort_prod_rdy", longint'(o_prod_rdy), 1);
        @(negedge i_clk);
        i_nrst = 1'b1;
        idle(1);
        send(16'd7, 1'b1);
        e.acc = 7; e.cnt = 1; e.ovf = 0;
        sb_q.push_back(e);
        idle(2);

        // Randomized bursts with random gaps and random result back-pressure.
        rdy_rand = 1'b1;
        for (int b = 0; b < 30; b++) begin
            burst(int'($urandom_range(1, 24)), -1, 2);
        end

        wait_cyc = 0;
        while (sb_q.size() != 0 && wait_cyc < 1000) begin
            idle(1);
            wait_cyc++;
        end
        chk("drain_pending", longint'(sb_q.size()), 0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
